// File: rtl/dac_cmd_queue.sv
// dac_cmd_queue: FIFO-buffered command scheduler driving the DAC SPI serializer.
// Optional feature macro DACQ_SHADOW_EN adds a 16x16 shadow of successfully written data.
module dac_cmd_queue #(
    parameter int DEPTH      = 8,
    parameter int AW         = 3,
    parameter int GAP_CYCLES = 64,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_comm,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [3:0]  dac_comm,
    output logic [3:0]  dac_addr,
    output logic [15:0] dac_data,
    output logic        dac_start,
    input  logic        dac_active,
    output logic        busy,
    output logic [AW:0] level,
    output logic        timeout_err,
    input  logic        err_clr
`ifdef DACQ_SHADOW_EN
    ,
    input  logic [3:0]  shadow_raddr,
    output logic [15:0] shadow_rdata
`endif
);

    // One counter serves both the frame timeout and the inter-frame gap.
    localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_dac_start, w_start_nxt;
    logic            w_pop, w_push, w_full, w_set_err, w_frame_ok;

    logic [23:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_level;
    logic [3:0]      r_comm, r_addr;
    logic [15:0]     r_data;
    logic            r_err;

    assign w_full   = (r_level == (AW+1)'(DEPTH));
    assign w_push   = wr_valid & ~w_full;
    assign wr_ready = ~w_full;

    // NOTE: the payload array has no reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {wr_comm, wr_addr, wr_data};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start_nxt = r_dac_start;
        w_pop       = 1'b0;
        w_set_err   = 1'b0;
        w_frame_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_START;
            end
            S_START, S_ACTIVE: begin
                // A completed frame takes precedence over a coincident timeout.
                if (r_state == S_ACTIVE && !dac_active) begin
                    w_start_nxt = 1'b0;
                    w_frame_ok  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_start_nxt = 1'b0;
                    w_set_err   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_state == S_START && dac_active) w_state_nxt = S_ACTIVE;
                end
            end
            S_GAP: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dac_start <= 1'b0;
            r_comm      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dac_start <= w_start_nxt;
            if (w_pop) {r_comm, r_addr, r_data} <= r_mem[r_rptr];
            if (w_set_err)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign dac_comm    = r_comm;
    assign dac_addr    = r_addr;
    assign dac_data    = r_data;
    assign dac_start   = r_dac_start;
    assign level       = r_level;
    assign timeout_err = r_err;
    assign busy        = (r_state != S_IDLE) | (r_level != '0);

`ifdef DACQ_SHADOW_EN
    // Small enough to clear on reset, so unwritten addresses read back as zero.
    logic [15:0] r_shadow [16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_shadow[i] <= '0;
        end else if (w_frame_ok) begin
            r_shadow[r_addr] <= r_data;
        end
    end

    assign shadow_rdata = r_shadow[shadow_raddr];
`endif

endmodule

// File: tb/tb_dac_cmd_queue.sv
// Scoreboard bench for dac_cmd_queue: expected frames queued at push, checked on each dac_start rise.
// Build with +define+DACQ_SHADOW_EN to also exercise the shadow RAM.
module tb_dac_cmd_queue;

    localparam int DEPTH      = 8;
    localparam int AW         = 3;
    localparam int GAP_CYCLES = 64;
    localparam int TIMEOUT    = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_comm = '0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  dac_comm;
    logic [3:0]  dac_addr;
    logic [15:0] dac_data;
    logic        dac_start;
    logic        dac_active;
    logic        busy;
    logic [AW:0] level;
    logic        timeout_err;
    logic        err_clr = 1'b0;
`ifdef DACQ_SHADOW_EN
    logic [3:0]  shadow_raddr = '0;
    logic [15:0] shadow_rdata;
`endif

    dac_cmd_queue #(
        .DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_comm(wr_comm), .wr_addr(wr_addr), .wr_data(wr_data),
        .dac_comm(dac_comm), .dac_addr(dac_addr), .dac_data(dac_data),
        .dac_start(dac_start), .dac_active(dac_active),
        .busy(busy), .level(level),
        .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef DACQ_SHADOW_EN
        , .shadow_raddr(shadow_raddr), .shadow_rdata(shadow_rdata)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [23:0] exp_q [$];

    int ser_delay = 2;
    int ser_len   = 3;
    bit ser_never = 1'b0;

    int n_rises = 0;
    int n_falls = 0;
    int last_hi = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        n_vec++;
        if (act < min) begin
            n_err++;
            $display("FAIL %s: got %0d, expected at least %0d (t=%0t)", name, act, min, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Returns 1 ns after the accepting clock edge.
    task automatic push(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
        int w = 0;
        wr_valid = 1'b1;
        wr_comm  = c;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!wr_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push_ready: wr_ready stuck at 0, expected 1 within 500 cycles");
        end else begin
            exp_q.push_back({c, a, d});
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_fall(input int max);
        int target = n_falls + 1;
        int w = 0;
        while (n_falls < target && w < max) begin
            tick();
            w++;
        end
        check("frame_end_seen", 64'(n_falls >= target), 64'd1);
    endtask

    task automatic wait_rise(input int max);
        int target = n_rises + 1;
        int w = 0;
        while (n_rises < target && w < max) begin
            tick();
            w++;
        end
        check("frame_start_seen", 64'(n_rises >= target), 64'd1);
    endtask

    task automatic wait_idle(input int max);
        int w = 0;
        while ((busy || exp_q.size() != 0) && w < max) begin
            tick();
            w++;
        end
        check("drain_idle", 64'(!busy && exp_q.size() == 0), 64'd1);
    endtask

    // Serializer model: raises spi_enable ser_delay cycles after ext_ctrl rises, for ser_len cycles.
    initial begin : ser_model
        dac_active = 1'b0;
        forever begin
            @(posedge dac_start);
            if (!ser_never) begin
                for (int i = 0; i < ser_delay && rst_n; i++) @(posedge clk);
                if (rst_n) begin
                    #1 dac_active = 1'b1;
                    for (int i = 0; i < ser_len && rst_n; i++) @(posedge clk);
                    #1 dac_active = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each frame start and checks the inter-frame gap.
    initial begin : monitor
        logic        prev_start = 1'b0;
        bit          have_fall = 1'b0;
        int          hi_len = 0;
        int          lo_len = 0;
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                prev_start = 1'b0;
                have_fall  = 1'b0;
                hi_len     = 0;
            end else begin
                if (dac_start && !prev_start) begin
                    n_rises++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {dac_comm, dac_addr, dac_data}, 64'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_payload", {dac_comm, dac_addr, dac_data}, e);
                    end
                    if (have_fall) check_ge("inter_frame_gap", lo_len, GAP_CYCLES);
                    hi_len = 1;
                end else if (dac_start) begin
                    hi_len++;
                end else if (prev_start) begin
                    last_hi   = hi_len;
                    have_fall = 1'b1;
                    lo_len    = 1;
                    n_falls++;
                end else begin
                    lo_len++;
                end
                prev_start = dac_start;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_level", level, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_dac_start", dac_start, 0);
        check("rst_dac_payload", {dac_comm, dac_addr, dac_data}, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
`ifdef DACQ_SHADOW_EN
        shadow_raddr = 4'd5;
        #1;
        check("rst_shadow", shadow_rdata, 0);
`endif

        // 1: single frame, 2-cycle latency, held until spi_enable falls
        ser_delay = 1024;
        ser_len   = 1024;
        push(4'd3, 4'd2, 16'hA5C3);
        check("t1_start_at_push", dac_start, 0);
        @(posedge clk); #1;
        check("t1_start_plus1", dac_start, 0);
        check("t1_level_popped", level, 0);
        @(posedge clk); #1;
        check("t1_start_plus2", dac_start, 1);
        check("t1_payload", {dac_comm, dac_addr, dac_data}, 24'h32A5C3);
        wait_fall(3000);
        check("t1_hold_cycles", last_hi, 2049);
        check("t1_busy_in_gap", busy, 1);
        repeat (GAP_CYCLES + 1) tick();
        check("t1_idle_after_gap", busy, 0);
        check("t1_payload_kept", {dac_comm, dac_addr, dac_data}, 24'h32A5C3);

        // 2: nine back-to-back pushes into an 8-deep queue
        ser_delay = 2;
        ser_len   = 3;
        c0 = cyc;
        for (int i = 0; i < 9; i++) push(4'h1, 4'(i), 16'h0100 + 16'(i));
        check("t2_no_stall", cyc - c0, 9);
        check("t2_level_full", level, 8);
        check("t2_wr_ready_full", wr_ready, 0);
        wait_idle(2000);
        check("t2_level_drained", level, 0);
        check("t2_wr_ready_drained", wr_ready, 1);

        // 3: timeout, sticky error, next entry still issued, err_clr
        ser_never = 1'b1;
        push(4'd2, 4'd7, 16'hDEAD);
        push(4'd2, 4'd8, 16'hBEEF);
        wait_fall(TIMEOUT + 100);
        check("t3_timeout_len", last_hi, TIMEOUT);
        check("t3_err_set", timeout_err, 1);
        ser_never = 1'b0;
        wait_fall(300);
        check("t3_next_frame_len", last_hi, 6);
        check("t3_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_err_cleared", timeout_err, 0);
        wait_idle(200);

        // 4: asynchronous reset in mid-ACTIVE
        ser_delay = 2;
        ser_len   = 20;
        push(4'd5, 4'd1, 16'h1111);
        push(4'd5, 4'd2, 16'h2222);
        push(4'd5, 4'd3, 16'h3333);
        wait_rise(50);
        repeat (4) tick();
        check("t4_start_before_rst", dac_start, 1);
        #3 rst_n = 1'b0;
        #1;
        check("t4_rst_dac_start", dac_start, 0);
        check("t4_rst_level", level, 0);
        check("t4_rst_wr_ready", wr_ready, 1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_payload", {dac_comm, dac_addr, dac_data}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ser_len = 3;
        push(4'd6, 4'd4, 16'h4444);
        wait_idle(300);

        // 5: push and pop in the same cycle at level 3, then pointer wrap
        push(4'd7, 4'd0, 16'h5000);
        push(4'd7, 4'd1, 16'h5001);
        push(4'd7, 4'd2, 16'h5002);
        push(4'd7, 4'd3, 16'h5003);
        wait_fall(100);
        repeat (GAP_CYCLES) tick();
        check("t5_level_before", level, 3);
        push(4'd7, 4'd4, 16'h5004);
        check("t5_level_pushpop", level, 3);
        wait_idle(2000);
        for (int i = 0; i < 20; i++) push(4'hC, 4'(i), 16'(i));
        wait_idle(3000);
        check("t5_level_after_wrap", level, 0);

`ifdef DACQ_SHADOW_EN
        // 6: shadow keeps the last successful write per address
        push(4'd1, 4'd5, 16'h1234);
        wait_idle(300);
        push(4'd1, 4'd5, 16'h5678);
        wait_idle(300);
        ser_never = 1'b1;
        push(4'd1, 4'd5, 16'h9999);
        wait_idle(TIMEOUT + 200);
        ser_never = 1'b0;
        shadow_raddr = 4'd5;
        #1;
        check("t6_shadow_addr5", shadow_rdata, 16'h5678);
        shadow_raddr = 4'd15;
        #1;
        check("t6_shadow_addr15", shadow_rdata, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
